// File: rtl/meas_report_sched_if.sv
// Byte-stream valid/ready link between the report scheduler and the UART/host path.
interface meas_report_sched_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/meas_report_sched.sv
// Periodic measurement snapshot and byte-frame serializer with overrun and frame counting.
// Optional checksum trailer byte is enabled by defining MEAS_CSUM_EN.
module meas_report_sched #(
  parameter int unsigned PERIOD_CYC = 5_000_000,
  parameter logic [7:0]  HEADER     = 8'hA5
) (
  input  logic                       clk_50M,
  input  logic                       rst,
  input  logic                       meas_en_i,
  input  logic [31:0]                duty_i,
  input  logic [19:0]                ad_freq_i,
  input  logic [7:0]                 ad_max_i,
  input  logic [7:0]                 ad_min_i,
  meas_report_sched_if.master        tx_if,
  output logic                       busy_o,
  output logic [15:0]                frame_cnt_o,
  output logic [7:0]                 overrun_cnt_o
);

  localparam logic [25:0] TimerMax = 26'(PERIOD_CYC - 1);
`ifdef MEAS_CSUM_EN
  localparam logic [3:0]  LastIdx  = 4'd10;
`else
  localparam logic [3:0]  LastIdx  = 4'd9;
`endif

  typedef enum logic [1:0] {StIdle, StWait, StSend} state_e;

  state_e      state_q, state_d;
  logic [25:0] timer_q, timer_d;
  logic [3:0]  idx_q, idx_d, idx_inc;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  overrun_q, overrun_d;

  logic [19:0] freq_q;
  logic [31:0] duty_q;
  logic [7:0]  max_q, min_q;
  logic [7:0]  max_s1_q, max_s2_q, min_s1_q, min_s2_q;

  logic        tick, xfer, snap;
  logic [7:0]  next_byte;

  assign tick    = (state_q != StIdle) && meas_en_i && (timer_q == TimerMax);
  assign xfer    = tx_valid_q && tx_if.tx_ready;
  assign idx_inc = idx_q + 4'd1;

  always_comb begin
    next_byte = 8'h00;
    case (idx_inc)
      4'd1:    next_byte = {4'b0000, freq_q[19:16]};
      4'd2:    next_byte = freq_q[15:8];
      4'd3:    next_byte = freq_q[7:0];
      4'd4:    next_byte = duty_q[31:24];
      4'd5:    next_byte = duty_q[23:16];
      4'd6:    next_byte = duty_q[15:8];
      4'd7:    next_byte = duty_q[7:0];
      4'd8:    next_byte = max_q;
      4'd9:    next_byte = min_q;
`ifdef MEAS_CSUM_EN
      4'd10:   next_byte = {4'b0000, freq_q[19:16]} + freq_q[15:8] + freq_q[7:0]
                         + duty_q[31:24] + duty_q[23:16] + duty_q[15:8] + duty_q[7:0]
                         + max_q + min_q;
`endif
      default: next_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    frame_cnt_d = frame_cnt_q;
    overrun_d   = overrun_q;
    snap        = 1'b0;
    timer_d     = 26'd0;
    if ((state_q != StIdle) && meas_en_i) begin
      timer_d = (timer_q == TimerMax) ? 26'd0 : timer_q + 26'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (meas_en_i) state_d = StWait;
      end
      StWait: begin
        if (!meas_en_i) begin
          state_d = StIdle;
        end else if (tick) begin
          state_d    = StSend;
          snap       = 1'b1;
          idx_d      = 4'd0;
          tx_data_d  = HEADER;
          tx_valid_d = 1'b1;
        end
      end
      StSend: begin
        // A tick mid-frame drops that period's report rather than restarting.
        if (tick && (overrun_q != 8'hFF)) overrun_d = overrun_q + 8'd1;
        if (xfer) begin
          if (idx_q == LastIdx) begin
            tx_valid_d  = 1'b0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = meas_en_i ? StWait : StIdle;
          end else begin
            idx_d     = idx_inc;
            tx_data_d = next_byte;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      timer_q     <= 26'd0;
      idx_q       <= 4'd0;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      frame_cnt_q <= 16'd0;
      overrun_q   <= 8'd0;
      freq_q      <= 20'd0;
      duty_q      <= 32'd0;
      max_q       <= 8'd0;
      min_q       <= 8'd0;
      max_s1_q    <= 8'd0;
      max_s2_q    <= 8'd0;
      min_s1_q    <= 8'd0;
      min_s2_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
      max_s1_q    <= ad_max_i;
      max_s2_q    <= max_s1_q;
      min_s1_q    <= ad_min_i;
      min_s2_q    <= min_s1_q;
      if (snap) begin
        freq_q <= ad_freq_i;
        duty_q <= duty_i;
        // Peak values cross from ad_clk; only take them when both stages agree.
        if (max_s1_q == max_s2_q) max_q <= max_s2_q;
        if (min_s1_q == min_s2_q) min_q <= min_s2_q;
      end
    end
  end

  assign tx_if.tx_data  = tx_data_q;
  assign tx_if.tx_valid = tx_valid_q;
  assign busy_o         = (state_q == StSend);
  assign frame_cnt_o    = frame_cnt_q;
  assign overrun_cnt_o  = overrun_q;

endmodule
